// File: rtl/key_pkg.sv
// Shared types, error codes and checksum helper for the serial key loader.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEY    = 2'd1,
        CHK    = 2'd2,
        VERIFY = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CHK  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    localparam int MAX_KEY_W = 256;
    localparam int MAX_CHK_W = 64;

    // Key bit i sits in slice i/chk_w at offset i%chk_w, so a bitwise fold
    // equals XOR-ing every chk_w-wide slice together.
    function automatic logic [MAX_CHK_W-1:0] xor_fold(
        input logic [MAX_KEY_W-1:0] key,
        input int                   key_w,
        input int                   chk_w
    );
        logic [MAX_CHK_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < MAX_KEY_W; i++) begin
            if (i < key_w) begin
                acc[i % chk_w] = acc[i % chk_w] ^ key[i];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/key_shift_rx.sv
// Serial receive datapath: key/checksum shift registers, bit counter and
// inter-bit idle timer. Emits strobes; the owning FSM decides what they mean.
module key_shift_rx #(
    parameter int KEY_W   = 24,
    parameter int CHK_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             xfer,
    input  logic             bit_in,
    input  logic             active,
    input  logic             abort,
    output logic [KEY_W-1:0] shadow_o,
    output logic [CHK_W-1:0] chk_o,
    output logic             key_done,
    output logic             chk_done,
    output logic             timeout
);
    localparam int CW = $clog2(KEY_W + CHK_W);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] KEY_LAST   = CW'(KEY_W - 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(KEY_W + CHK_W - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [CHK_W-1:0] chk_q, chk_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;

    always_comb begin
        shadow_d = shadow_q;
        chk_d    = chk_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        key_done = xfer && (cnt_q == KEY_LAST);
        chk_done = xfer && (cnt_q == FRAME_LAST);
        // Fires on the idle cycle whose edge would bring the count to TIMEOUT.
        timeout  = active && !xfer && (tmo_q == TMO_LAST);
        if (abort) begin
            shadow_d = '0;
            chk_d    = '0;
            cnt_d    = '0;
            tmo_d    = '0;
        end else if (xfer) begin
            if (cnt_q <= KEY_LAST) begin
                shadow_d = {bit_in, shadow_q[KEY_W-1:1]};
            end else begin
                chk_d = {bit_in, chk_q[CHK_W-1:1]};
            end
            cnt_d = chk_done ? '0 : cnt_q + 1'b1;
            tmo_d = '0;
        end else if (active) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            chk_q    <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            chk_q    <= chk_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
        end
    end

    assign shadow_o = shadow_q;
    assign chk_o    = chk_q;

endmodule

// File: rtl/key_loader.sv
// Key-delivery front end: receives a checksummed serial key frame, commits
// verified keys to the locked core, and supports zeroize and one-way lock.
module key_loader #(
    parameter int KEY_W   = 24,
    parameter int CHK_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_valid,
    input  logic             sin_data,
    output logic             sin_ready,
    input  logic             lock_i,
    input  logic             clear_i,
    output logic [KEY_W-1:0] key_o,
    output logic             key_valid_o,
    output logic             busy_o,
    output logic             locked_o,
    output logic             err_o,
    output logic [1:0]       err_code_o
);
    import key_pkg::*;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;

    logic             xfer, active, abort, lock_set, chk_ok;
    logic [KEY_W-1:0] shadow;
    logic [CHK_W-1:0] chk_rx;
    logic             key_done, chk_done, timeout;

    assign sin_ready = (state_q != VERIFY) && !locked_q;
    assign xfer      = sin_valid && sin_ready;
    assign active    = (state_q == KEY) || (state_q == CHK);
    assign lock_set  = lock_i && key_valid_q;
    assign chk_ok    = (chk_rx == CHK_W'(xor_fold(MAX_KEY_W'(shadow), KEY_W, CHK_W)));

    key_shift_rx #(
        .KEY_W   (KEY_W),
        .CHK_W   (CHK_W),
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .xfer     (xfer),
        .bit_in   (sin_data),
        .active   (active),
        .abort    (abort),
        .shadow_o (shadow),
        .chk_o    (chk_rx),
        .key_done (key_done),
        .chk_done (chk_done),
        .timeout  (timeout)
    );

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        locked_d    = locked_q | lock_set;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        abort       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    err_code_d = ERR_NONE;
                    state_d    = KEY;
                end
            end
            KEY: begin
                if (key_done) begin
                    state_d = CHK;
                end else if (timeout) begin
                    abort      = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = ERR_TMO;
                    state_d    = IDLE;
                end
            end
            CHK: begin
                if (chk_done) begin
                    state_d = VERIFY;
                end else if (timeout) begin
                    abort      = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = ERR_TMO;
                    state_d    = IDLE;
                end
            end
            VERIFY: begin
                if (chk_ok) begin
                    key_d       = shadow;
                    key_valid_d = 1'b1;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = ERR_CHK;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A lock landing mid-frame drops the frame quietly; in VERIFY the commit still stands.
        if (lock_set && active) begin
            abort      = 1'b1;
            err_d      = 1'b0;
            err_code_d = err_code_q;
            state_d    = IDLE;
        end

        // Zeroize overrides everything else, including a same-edge commit.
        if (clear_i) begin
            key_d       = '0;
            key_valid_d = 1'b0;
            abort       = 1'b1;
            err_d       = 1'b0;
            err_code_d  = err_code_q;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign key_o       = key_q;
    assign key_valid_o = key_valid_q;
    assign busy_o      = (state_q != IDLE);
    assign locked_o    = locked_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_key_loader.sv
// Scoreboard bench for key_loader: expected frame outcomes are queued by the
// stimulus and checked by a monitor whenever busy_o falls.
module tb_key_loader;
    localparam int KEY_W = 24;
    localparam int CHK_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sin_valid = 1'b0;
    logic             sin_data = 1'b0;
    logic             lock_i = 1'b0;
    logic             clear_i = 1'b0;
    logic             sin_ready;
    logic [KEY_W-1:0] key_o;
    logic             key_valid_o;
    logic             busy_o;
    logic             locked_o;
    logic             err_o;
    logic [1:0]       err_code_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [23:0] key;
        logic        valid;
        logic        err;
        logic [1:0]  code;
        logic        locked;
    } exp_t;

    exp_t exp_q[$];
    logic busy_prev = 1'b0;

    key_loader #(.KEY_W(KEY_W), .CHK_W(CHK_W), .TIMEOUT(255)) dut (
        .clk         (clk),
        .rst         (rst),
        .sin_valid   (sin_valid),
        .sin_data    (sin_data),
        .sin_ready   (sin_ready),
        .lock_i      (lock_i),
        .clear_i     (clear_i),
        .key_o       (key_o),
        .key_valid_o (key_valid_o),
        .busy_o      (busy_o),
        .locked_o    (locked_o),
        .err_o       (err_o),
        .err_code_o  (err_code_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end else begin
            $display("ok   %s value=0x%0h", name, act);
        end
    endtask

    task automatic expect_frame(input logic [23:0] k, input logic v, input logic e,
                                input logic [1:0] c, input logic l);
        exp_t x;
        x.key = k; x.valid = v; x.err = e; x.code = c; x.locked = l;
        exp_q.push_back(x);
    endtask

    // Starts and ends at a falling edge; waits (bounded) for sin_ready.
    task automatic send_bit(input logic b);
        int n;
        n = 0;
        sin_valid = 1'b1;
        sin_data  = b;
        while (!sin_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!sin_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_wait actual=0 required=1 after %0d cycles", n);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [23:0] k, input logic [7:0] c);
        for (int i = 0; i < KEY_W; i++) send_bit(k[i]);
        for (int i = 0; i < CHK_W; i++) send_bit(c[i]);
        sin_valid = 1'b0;
    endtask

    // Monitor: a frame outcome is visible the first sample after busy_o falls.
    always @(negedge clk) begin
        exp_t e;
        if (busy_prev && !busy_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame_end actual=key 0x%0h required=no event", key_o);
            end else begin
                e = exp_q.pop_front();
                check("mon_key", 32'(key_o), 32'(e.key));
                check("mon_key_valid", 32'(key_valid_o), 32'(e.valid));
                check("mon_err", 32'(err_o), 32'(e.err));
                check("mon_err_code", 32'(err_code_o), 32'(e.code));
                check("mon_locked", 32'(locked_o), 32'(e.locked));
            end
        end
        busy_prev = busy_o;
    end

    initial begin
        logic [31:0] raw;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_key", 32'(key_o), 32'h0);
        check("rst_key_valid", 32'(key_valid_o), 32'h0);
        check("rst_locked", 32'(locked_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        check("rst_err_code", 32'(err_code_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(sin_ready), 32'h1);

        // Good load: commit lands two edges after the last bit
        expect_frame(24'hA5C33C, 1'b1, 1'b0, 2'b00, 1'b0);
        send_frame(24'hA5C33C, 8'h5A);
        check("verify_no_commit_yet", 32'(key_valid_o), 32'h0);
        check("verify_not_ready", 32'(sin_ready), 32'h0);
        @(negedge clk);
        check("good_key", 32'(key_o), 32'hA5C33C);

        // Bad checksum: 0x123456 folds to 0x70, 0x00 sent
        expect_frame(24'hA5C33C, 1'b1, 1'b1, 2'b01, 1'b0);
        send_frame(24'h123456, 8'h00);
        @(negedge clk);
        check("bad_err_pulse", 32'(err_o), 32'h1);
        @(negedge clk);
        check("bad_err_one_cycle", 32'(err_o), 32'h0);
        check("bad_code_held", 32'(err_code_o), 32'h1);

        // Timeout: 10 bits, then 255 idle cycles
        expect_frame(24'hA5C33C, 1'b1, 1'b1, 2'b10, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        sin_valid = 1'b0;
        repeat (254) @(negedge clk);
        check("tmo_not_early", 32'(busy_o), 32'h1);
        @(negedge clk);
        check("tmo_busy", 32'(busy_o), 32'h0);
        check("tmo_code", 32'(err_code_o), 32'h2);
        @(negedge clk);
        check("tmo_err_one_cycle", 32'(err_o), 32'h0);
        expect_frame(24'h000001, 1'b1, 1'b0, 2'b00, 1'b0);
        send_frame(24'h000001, 8'h01);
        @(negedge clk);
        check("after_tmo_key", 32'(key_o), 32'h000001);

        // Clear in the VERIFY cycle wins over the commit
        expect_frame(24'h000000, 1'b0, 1'b0, 2'b00, 1'b0);
        send_frame(24'hA5C33C, 8'h5A);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check("clear_vs_commit_key", 32'(key_o), 32'h0);

        // Back-to-back frames
        expect_frame(24'h000001, 1'b1, 1'b0, 2'b00, 1'b0);
        expect_frame(24'hA5C33C, 1'b1, 1'b0, 2'b00, 1'b0);
        send_frame(24'h000001, 8'h01);
        send_frame(24'hA5C33C, 8'h5A);
        @(negedge clk);
        check("b2b_key", 32'(key_o), 32'hA5C33C);

        // Lock, then a frame must be refused
        lock_i = 1'b1;
        @(negedge clk);
        lock_i = 1'b0;
        check("lock_set", 32'(locked_o), 32'h1);
        check("lock_not_ready", 32'(sin_ready), 32'h0);
        raw = {8'h01, 24'h000001};
        for (int i = 0; i < 32; i++) begin
            sin_valid = 1'b1;
            sin_data  = raw[i];
            @(negedge clk);
        end
        sin_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("locked_key_kept", 32'(key_o), 32'hA5C33C);
        check("locked_not_busy", 32'(busy_o), 32'h0);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check("locked_clear_key", 32'(key_o), 32'h0);
        check("locked_clear_valid", 32'(key_valid_o), 32'h0);
        check("clear_keeps_lock", 32'(locked_o), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_unlocks", 32'(locked_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Async reset while in CHK, checked before the next rising edge
        expect_frame(24'hA5C33C, 1'b1, 1'b0, 2'b00, 1'b0);
        send_frame(24'hA5C33C, 8'h5A);
        @(negedge clk);
        for (int i = 0; i < KEY_W; i++) send_bit(raw[i]);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        check("mid_chk_busy", 32'(busy_o), 32'h1);
        expect_frame(24'h000000, 1'b0, 1'b0, 2'b00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_key", 32'(key_o), 32'h0);
        check("async_rst_valid", 32'(key_valid_o), 32'h0);
        check("async_rst_busy", 32'(busy_o), 32'h0);
        @(negedge clk);
        sin_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
